// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl
//   Time-multiplexes one shared 7-segment decoder across two common-anode
//   digits. The scan order is SHOW0 -> BLANK0 -> SHOW1 -> BLANK1. The blanking
//   gaps between the lit phases prevent ghosting. New digit pairs are staged
//   and swapped in only at the frame boundary, which is the BLANK1 -> SHOW0
//   transition. A frame therefore always displays one consistent pair.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   load        1-cycle strobe: capture d0/d1 as the next digit pair
//   d0, d1      next values for digit 0 (right) and digit 1 (left)
//   s           nibble driven to the shared decoder
//   en_n        active-low anode enables: [0] = digit0, [1] = digit1
//   frame_done  1-cycle pulse on each frame-boundary cycle
//   pending     high while a loaded pair waits for the next boundary
module display_mux_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [3:0] s,
  output logic [1:0] en_n,
  output logic       frame_done,
  output logic       pending
);

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       sh0, sh1, sh0_nxt, sh1_nxt;
  logic [3:0]       pd0, pd1;
  logic             pend;
  logic             last, boundary;
  logic [1:0]       en_n_nxt;
  logic [3:0]       s_nxt;
  logic             frame_done_nxt;

  always_comb begin
    last      = 1'b0;
    boundary  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    sh0_nxt   = sh0;
    sh1_nxt   = sh1;

    if (state == SHOW0 || state == SHOW1) last = (cnt == REFRESH_LAST);
    else                                  last = (cnt == BLANK_LAST);
    boundary = (state == BLANK1) && last;

    if (last) begin
      cnt_nxt = '0;
      unique case (state)
        SHOW0:   state_nxt = BLANK0;
        BLANK0:  state_nxt = SHOW1;
        SHOW1:   state_nxt = BLANK1;
        default: state_nxt = SHOW0;
      endcase
    end

    // A load that coincides with the boundary bypasses the pending registers.
    if (boundary) begin
      if (load) begin
        sh0_nxt = d0;
        sh1_nxt = d1;
      end else if (pend) begin
        sh0_nxt = pd0;
        sh1_nxt = pd1;
      end
    end
  end

  // The outputs are registered. They are decoded from the next-state values,
  // so they line up with the state register on the same clock edge. The
  // blanking phases pre-present the digit that lights next.
  always_comb begin
    en_n_nxt = 2'b11;
    s_nxt    = sh0_nxt;
    unique case (state_nxt)
      SHOW0:   begin en_n_nxt = 2'b10; s_nxt = sh0_nxt; end
      BLANK0:  begin en_n_nxt = 2'b11; s_nxt = sh1_nxt; end
      SHOW1:   begin en_n_nxt = 2'b01; s_nxt = sh1_nxt; end
      default: begin en_n_nxt = 2'b11; s_nxt = sh0_nxt; end
    endcase
    frame_done_nxt = (state_nxt == BLANK1) && (cnt_nxt == BLANK_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK1;
      cnt        <= '0;
      sh0        <= '0;
      sh1        <= '0;
      pd0        <= '0;
      pd1        <= '0;
      pend       <= 1'b0;
      en_n       <= 2'b11;
      s          <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh0   <= sh0_nxt;
      sh1   <= sh1_nxt;
      if (load && !boundary) begin
        pd0  <= d0;
        pd1  <= d1;
        pend <= 1'b1;
      end else if (boundary) begin
        pend <= 1'b0;
      end
      en_n       <= en_n_nxt;
      s          <= s_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  assign pending = pend;

endmodule

// File: tb/tb_display_mux_ctrl.sv
module tb_display_mux_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] d0, d1;
  logic [3:0] s;
  logic [1:0] en_n;
  logic       frame_done;
  logic       pending;

  int errors = 0;
  int checks = 0;

  display_mux_ctrl #(
    .REFRESH_CYCLES(4),
    .BLANK_CYCLES  (2),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .d0        (d0),
    .d1        (d1),
    .s         (s),
    .en_n      (en_n),
    .frame_done(frame_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] en;
    logic [3:0] s;
    logic       fd;
    logic       pd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic ld, input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] en, input logic [3:0] sv, input logic fd, input logic pd);
    vec_t v;
    v.load = ld; v.d0 = a; v.d1 = b; v.en = en; v.s = sv; v.fd = fd; v.pd = pd;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] en, input logic [3:0] sv,
                     input logic fd, input logic pd);
    checks++;
    if (en_n !== en || s !== sv || frame_done !== fd || pending !== pd) begin
      errors++;
      $display("FAIL %s: got en_n=%b s=%h fd=%b pend=%b, expected en_n=%b s=%h fd=%b pend=%b",
               name, en_n, s, frame_done, pending, en, sv, fd, pd);
    end
  endtask

  // Both anodes must never be enabled together.
  always @(negedge clk) begin
    checks++;
    if (en_n === 2'b00) begin
      errors++;
      $display("FAIL en_n_never_00: got en_n=%b, expected not 00", en_n);
    end
  end

  initial begin
    // The timeline starts at reset release. The boundary cycles are t = 1 + 12k.
    add(1, 1, 4'h5, 4'hA, 2'b11, 4'h0, 0, 0); // t0  load 5/A
    add(1, 0, 0, 0,       2'b11, 4'h0, 1, 1); // t1  release boundary
    add(4, 0, 0, 0,       2'b10, 4'h5, 0, 0); // frame 1
    add(2, 0, 0, 0,       2'b11, 4'hA, 0, 0);
    add(4, 0, 0, 0,       2'b01, 4'hA, 0, 0);
    add(1, 0, 0, 0,       2'b11, 4'h5, 0, 0);
    add(1, 0, 0, 0,       2'b11, 4'h5, 1, 0);
    add(4, 0, 0, 0,       2'b10, 4'h5, 0, 0); // frame 2
    add(2, 0, 0, 0,       2'b11, 4'hA, 0, 0);
    add(4, 0, 0, 0,       2'b01, 4'hA, 0, 0);
    add(1, 0, 0, 0,       2'b11, 4'h5, 0, 0);
    add(1, 0, 0, 0,       2'b11, 4'h5, 1, 0);
    add(4, 0, 0, 0,       2'b10, 4'h5, 0, 0); // frame 3: load 1/2 in SHOW1
    add(2, 0, 0, 0,       2'b11, 4'hA, 0, 0);
    add(1, 1, 4'h1, 4'h2, 2'b01, 4'hA, 0, 0);
    add(3, 0, 0, 0,       2'b01, 4'hA, 0, 1);
    add(1, 0, 0, 0,       2'b11, 4'h5, 0, 1);
    add(1, 0, 0, 0,       2'b11, 4'h5, 1, 1);
    add(2, 0, 0, 0,       2'b10, 4'h1, 0, 0); // frame 4: load 3/4 then 8/9
    add(1, 1, 4'h3, 4'h4, 2'b10, 4'h1, 0, 0);
    add(1, 0, 0, 0,       2'b10, 4'h1, 0, 1);
    add(2, 0, 0, 0,       2'b11, 4'h2, 0, 1);
    add(1, 0, 0, 0,       2'b01, 4'h2, 0, 1);
    add(1, 1, 4'h8, 4'h9, 2'b01, 4'h2, 0, 1);
    add(2, 0, 0, 0,       2'b01, 4'h2, 0, 1);
    add(1, 0, 0, 0,       2'b11, 4'h1, 0, 1);
    add(1, 0, 0, 0,       2'b11, 4'h1, 1, 1);
    add(4, 0, 0, 0,       2'b10, 4'h8, 0, 0); // frame 5: load C/D on boundary
    add(2, 0, 0, 0,       2'b11, 4'h9, 0, 0);
    add(4, 0, 0, 0,       2'b01, 4'h9, 0, 0);
    add(1, 0, 0, 0,       2'b11, 4'h8, 0, 0);
    add(1, 1, 4'hC, 4'hD, 2'b11, 4'h8, 1, 0);
    add(4, 0, 0, 0,       2'b10, 4'hC, 0, 0); // frame 6
    add(2, 0, 0, 0,       2'b11, 4'hD, 0, 0);
    add(2, 0, 0, 0,       2'b01, 4'hD, 0, 0);

    // Reset is held with a load active; the load must be ignored.
    reset = 1'b1; load = 1'b1; d0 = 4'h7; d1 = 4'h3;
    #1 chk("reset_async", 2'b11, 4'h0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_hold", 2'b11, 4'h0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("vec_t%0d", i), vecs[i].en, vecs[i].s, vecs[i].fd, vecs[i].pd);
      load = vecs[i].load; d0 = vecs[i].d0; d1 = vecs[i].d1;
    end

    // Assert reset in SHOW1 while a pair is pending.
    @(negedge clk);
    chk("show1_before_load", 2'b01, 4'hD, 0, 0);
    load = 1'b1; d0 = 4'h6; d1 = 4'h7;
    @(negedge clk);
    chk("show1_pending", 2'b01, 4'hD, 0, 1);
    load = 1'b0;
    #2 reset = 1'b1;
    #1 chk("midframe_reset", 2'b11, 4'h0, 0, 0);
    repeat (2) @(negedge clk);
    chk("midframe_reset_hold", 2'b11, 4'h0, 0, 0);
    reset = 1'b0;
    chk("rel_t0", 2'b11, 4'h0, 0, 0);
    @(negedge clk);
    chk("rel_t1_boundary", 2'b11, 4'h0, 1, 0);
    @(negedge clk);
    chk("rel_show0_old_pair", 2'b10, 4'h0, 0, 0);
    @(negedge clk);
    chk("rel_show0_dwell", 2'b10, 4'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
